mul_rs_dispatch: RTL and testbench

- Reservation station for the multiply/divide execution unit: 3-entry operand buffer that sits between issue and the mul/div exec unit, i.e. the initiator side of the exec dispatch interface.
- Accepts issued mul/div ops, snoops the result broadcast bus to wake waiting operands, selects one ready entry, hands it to the exec unit with a valid/ready handshake, and frees the entry when the exec unit reports completion.

---
 rtl/mul_rs_dispatch_if.sv | 33 +++
 rtl/mul_rs_dispatch.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mul_rs_dispatch.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_rs_dispatch_if.sv
`default_nettype none
// ============================================================================
//  Module      : mul_rs_dispatch_if
//  Description : Exec dispatch interface between the mul/div reservation
//                station (master, initiator) and the mul/div exec unit (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface mul_rs_dispatch_if #(
    parameter int DW = 8,
    parameter int TW = 3
);
    logic          ex_valid;
    logic          ex_ready;
    logic [DW-1:0] ex_rs1_data;
    logic [DW-1:0] ex_rs2_data;
    logic [3:0]    ex_func;
    logic [3:0]    ex_rd;
    logic [TW-1:0] ex_rob;
    logic [2:0]    ex_rs_index;
    logic          ex_done;
    logic [2:0]    ex_done_index;

    modport master (
        output ex_valid, ex_rs1_data, ex_rs2_data, ex_func, ex_rd, ex_rob, ex_rs_index,
        input  ex_ready, ex_done, ex_done_index
    );

    modport slave (
        input  ex_valid, ex_rs1_data, ex_rs2_data, ex_func, ex_rd, ex_rob, ex_rs_index,
        output ex_ready, ex_done, ex_done_index
    );
endinterface
`default_nettype wire

// File: rtl/mul_rs_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : mul_rs_dispatch
//  Description : Reservation station for the mul/div unit. Buffers issued ops,
//                wakes pending operands from the result broadcast bus, and
//                dispatches one READY entry at a time to the exec unit.
//  Revision    : 1.0  initial release
// ============================================================================
module mul_rs_dispatch #(
    parameter int DEPTH = 3,
    parameter int DW    = 8,
    parameter int TW    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          flush,
    input  wire logic          iss_valid,
    output logic               iss_ready,
    input  wire logic [3:0]    iss_func,
    input  wire logic [3:0]    iss_rd,
    input  wire logic [TW-1:0] iss_rob,
    input  wire logic          iss_j_rdy,
    input  wire logic          iss_k_rdy,
    input  wire logic [DW-1:0] iss_j_val,
    input  wire logic [DW-1:0] iss_k_val,
    input  wire logic [TW-1:0] iss_j_tag,
    input  wire logic [TW-1:0] iss_k_tag,
    input  wire logic          cdb_valid,
    input  wire logic [TW-1:0] cdb_tag,
    input  wire logic [DW-1:0] cdb_data,
    mul_rs_dispatch_if.master  ex,
    output logic               illegal_func,
    output logic [1:0]         occupancy
);
    localparam int       IW       = 3;
    localparam bit [3:0] C_FN_MUL = 4'b0010;
    localparam bit [3:0] C_FN_DIV = 4'b0011;

    typedef enum logic [1:0] {
        ST_FREE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_READY = 2'd2,
        ST_EXEC  = 2'd3
    } entry_state_t;

    // Entry storage
    entry_state_t  r_state  [DEPTH];
    logic [3:0]    r_func   [DEPTH];
    logic [3:0]    r_rd     [DEPTH];
    logic [TW-1:0] r_rob    [DEPTH];
    logic          r_j_rdy  [DEPTH];
    logic          r_k_rdy  [DEPTH];
    logic [DW-1:0] r_j_val  [DEPTH];
    logic [DW-1:0] r_k_val  [DEPTH];
    logic [TW-1:0] r_j_tag  [DEPTH];
    logic [TW-1:0] r_k_tag  [DEPTH];

    entry_state_t  w_state_nx [DEPTH];
    logic [3:0]    w_func_nx  [DEPTH];
    logic [3:0]    w_rd_nx    [DEPTH];
    logic [TW-1:0] w_rob_nx   [DEPTH];
    logic          w_j_rdy_nx [DEPTH];
    logic          w_k_rdy_nx [DEPTH];
    logic [DW-1:0] w_j_val_nx [DEPTH];
    logic [DW-1:0] w_k_val_nx [DEPTH];
    logic [TW-1:0] w_j_tag_nx [DEPTH];
    logic [TW-1:0] w_k_tag_nx [DEPTH];

    // Dispatch output registers
    logic          r_ex_valid,    w_ex_valid_nx;
    logic [DW-1:0] r_ex_rs1,      w_ex_rs1_nx;
    logic [DW-1:0] r_ex_rs2,      w_ex_rs2_nx;
    logic [3:0]    r_ex_func,     w_ex_func_nx;
    logic [3:0]    r_ex_rd,       w_ex_rd_nx;
    logic [TW-1:0] r_ex_rob,      w_ex_rob_nx;
    logic [IW-1:0] r_ex_idx,      w_ex_idx_nx;
    logic          r_illegal,     w_illegal_nx;
    logic [1:0]    r_occ,         w_occ_nx;

    logic          w_free_any, w_rdy_any, w_exec_any;
    logic [IW-1:0] w_free_idx, w_rdy_idx;
    logic          w_func_ok, w_issue;
    logic          w_bj, w_bk;

    assign w_func_ok = (iss_func == C_FN_MUL) || (iss_func == C_FN_DIV);
    assign iss_ready = w_free_any;
    assign w_issue   = iss_valid && w_free_any && w_func_ok;

    // Issue-time bypass: a broadcast in the allocation cycle satisfies a pending operand
    assign w_bj = cdb_valid && !iss_j_rdy && (iss_j_tag == cdb_tag);
    assign w_bk = cdb_valid && !iss_k_rdy && (iss_k_tag == cdb_tag);

    assign ex.ex_valid    = r_ex_valid;
    assign ex.ex_rs1_data = r_ex_rs1;
    assign ex.ex_rs2_data = r_ex_rs2;
    assign ex.ex_func     = r_ex_func;
    assign ex.ex_rd       = r_ex_rd;
    assign ex.ex_rob      = r_ex_rob;
    assign ex.ex_rs_index = r_ex_idx;
    assign illegal_func   = r_illegal;
    assign occupancy      = r_occ;

    // Priority pickers over start-of-cycle state: lowest FREE, lowest READY, any EXEC
    always_comb begin
        w_free_any = 1'b0;
        w_free_idx = '0;
        w_rdy_any  = 1'b0;
        w_rdy_idx  = '0;
        w_exec_any = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (r_state[i] == ST_FREE) begin
                w_free_any = 1'b1;
                w_free_idx = IW'(i);
            end
            if (r_state[i] == ST_READY) begin
                w_rdy_any = 1'b1;
                w_rdy_idx = IW'(i);
            end
            if (r_state[i] == ST_EXEC) begin
                w_exec_any = 1'b1;
            end
        end
    end

    // Next-state: flush, wakeup, completion, handshake/dispatch, allocation
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_state_nx[i] = r_state[i];
            w_func_nx[i]  = r_func[i];
            w_rd_nx[i]    = r_rd[i];
            w_rob_nx[i]   = r_rob[i];
            w_j_rdy_nx[i] = r_j_rdy[i];
            w_k_rdy_nx[i] = r_k_rdy[i];
            w_j_val_nx[i] = r_j_val[i];
            w_k_val_nx[i] = r_k_val[i];
            w_j_tag_nx[i] = r_j_tag[i];
            w_k_tag_nx[i] = r_k_tag[i];
        end
        w_ex_valid_nx = r_ex_valid;
        w_ex_rs1_nx   = r_ex_rs1;
        w_ex_rs2_nx   = r_ex_rs2;
        w_ex_func_nx  = r_ex_func;
        w_ex_rd_nx    = r_ex_rd;
        w_ex_rob_nx   = r_ex_rob;
        w_ex_idx_nx   = r_ex_idx;
        w_illegal_nx  = 1'b0;
        w_occ_nx      = 2'd0;

        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_state_nx[i] = ST_FREE;
            end
            w_ex_valid_nx = 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                // Operand wakeup from the broadcast bus
                if (r_state[i] == ST_WAIT) begin
                    if (cdb_valid && !r_j_rdy[i] && (r_j_tag[i] == cdb_tag)) begin
                        w_j_rdy_nx[i] = 1'b1;
                        w_j_val_nx[i] = cdb_data;
                    end
                    if (cdb_valid && !r_k_rdy[i] && (r_k_tag[i] == cdb_tag)) begin
                        w_k_rdy_nx[i] = 1'b1;
                        w_k_val_nx[i] = cdb_data;
                    end
                    if (w_j_rdy_nx[i] && w_k_rdy_nx[i]) begin
                        w_state_nx[i] = ST_READY;
                    end
                end
                // Completion only frees an entry that is actually executing
                if (ex.ex_done && (ex.ex_done_index == IW'(i)) && (r_state[i] == ST_EXEC)) begin
                    w_state_nx[i] = ST_FREE;
                end
            end

            if (r_ex_valid && ex.ex_ready) begin
                w_ex_valid_nx = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    if ((r_ex_idx == IW'(i)) && (r_state[i] == ST_READY)) begin
                        w_state_nx[i] = ST_EXEC;
                    end
                end
            end else if (!r_ex_valid && !w_exec_any && w_rdy_any) begin
                w_ex_valid_nx = 1'b1;
                w_ex_idx_nx   = w_rdy_idx;
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_rdy_idx == IW'(i)) begin
                        w_ex_rs1_nx  = r_j_val[i];
                        w_ex_rs2_nx  = r_k_val[i];
                        w_ex_func_nx = r_func[i];
                        w_ex_rd_nx   = r_rd[i];
                        w_ex_rob_nx  = r_rob[i];
                    end
                end
            end

            // Allocation targets an entry that was FREE at the start of the cycle
            if (w_issue) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_free_idx == IW'(i)) begin
                        w_func_nx[i]  = iss_func;
                        w_rd_nx[i]    = iss_rd;
                        w_rob_nx[i]   = iss_rob;
                        w_j_tag_nx[i] = iss_j_tag;
                        w_k_tag_nx[i] = iss_k_tag;
                        w_j_rdy_nx[i] = iss_j_rdy || w_bj;
                        w_k_rdy_nx[i] = iss_k_rdy || w_bk;
                        w_j_val_nx[i] = w_bj ? cdb_data : iss_j_val;
                        w_k_val_nx[i] = w_bk ? cdb_data : iss_k_val;
                        w_state_nx[i] = ((iss_j_rdy || w_bj) && (iss_k_rdy || w_bk))
                                        ? ST_READY : ST_WAIT;
                    end
                end
            end

            w_illegal_nx = iss_valid && !w_func_ok;
        end

        for (int i = 0; i < DEPTH; i++) begin
            if (w_state_nx[i] != ST_FREE) begin
                w_occ_nx = w_occ_nx + 2'd1;
            end
        end
    end

    // State and payload registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= ST_FREE;
                r_func[i]  <= '0;
                r_rd[i]    <= '0;
                r_rob[i]   <= '0;
                r_j_rdy[i] <= 1'b0;
                r_k_rdy[i] <= 1'b0;
                r_j_val[i] <= '0;
                r_k_val[i] <= '0;
                r_j_tag[i] <= '0;
                r_k_tag[i] <= '0;
            end
            r_ex_valid <= 1'b0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_func  <= '0;
            r_ex_rd    <= '0;
            r_ex_rob   <= '0;
            r_ex_idx   <= '0;
            r_illegal  <= 1'b0;
            r_occ      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_func[i]  <= w_func_nx[i];
                r_rd[i]    <= w_rd_nx[i];
                r_rob[i]   <= w_rob_nx[i];
                r_j_rdy[i] <= w_j_rdy_nx[i];
                r_k_rdy[i] <= w_k_rdy_nx[i];
                r_j_val[i] <= w_j_val_nx[i];
                r_k_val[i] <= w_k_val_nx[i];
                r_j_tag[i] <= w_j_tag_nx[i];
                r_k_tag[i] <= w_k_tag_nx[i];
            end
            r_ex_valid <= w_ex_valid_nx;
            r_ex_rs1   <= w_ex_rs1_nx;
            r_ex_rs2   <= w_ex_rs2_nx;
            r_ex_func  <= w_ex_func_nx;
            r_ex_rd    <= w_ex_rd_nx;
            r_ex_rob   <= w_ex_rob_nx;
            r_ex_idx   <= w_ex_idx_nx;
            r_illegal  <= w_illegal_nx;
            r_occ      <= w_occ_nx;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_mul_rs_dispatch.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_rs_dispatch
//  Description : Directed self-checking bench for mul_rs_dispatch.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mul_rs_dispatch;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       iss_valid = 1'b0;
    logic       iss_ready;
    logic [3:0] iss_func = '0;
    logic [3:0] iss_rd = '0;
    logic [2:0] iss_rob = '0;
    logic       iss_j_rdy = 1'b0;
    logic       iss_k_rdy = 1'b0;
    logic [7:0] iss_j_val = '0;
    logic [7:0] iss_k_val = '0;
    logic [2:0] iss_j_tag = '0;
    logic [2:0] iss_k_tag = '0;
    logic       cdb_valid = 1'b0;
    logic [2:0] cdb_tag = '0;
    logic [7:0] cdb_data = '0;
    logic       illegal_func;
    logic [1:0] occupancy;

    int n_pass = 0;
    int n_total = 0;

    mul_rs_dispatch_if #(.DW(8), .TW(3)) ex_if ();

    mul_rs_dispatch #(.DEPTH(3), .DW(8), .TW(3)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .iss_valid    (iss_valid),
        .iss_ready    (iss_ready),
        .iss_func     (iss_func),
        .iss_rd       (iss_rd),
        .iss_rob      (iss_rob),
        .iss_j_rdy    (iss_j_rdy),
        .iss_k_rdy    (iss_k_rdy),
        .iss_j_val    (iss_j_val),
        .iss_k_val    (iss_k_val),
        .iss_j_tag    (iss_j_tag),
        .iss_k_tag    (iss_k_tag),
        .cdb_valid    (cdb_valid),
        .cdb_tag      (cdb_tag),
        .cdb_data     (cdb_data),
        .ex           (ex_if),
        .illegal_func (illegal_func),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive_issue(input logic [3:0] fn, input logic [3:0] rd, input logic [2:0] rob,
                               input logic jr, input logic [7:0] jv, input logic [2:0] jt,
                               input logic kr, input logic [7:0] kv, input logic [2:0] kt);
        iss_valid = 1'b1;
        iss_func  = fn;
        iss_rd    = rd;
        iss_rob   = rob;
        iss_j_rdy = jr;
        iss_j_val = jv;
        iss_j_tag = jt;
        iss_k_rdy = kr;
        iss_k_val = kv;
        iss_k_tag = kt;
    endtask

    initial begin
        ex_if.ex_ready      = 1'b0;
        ex_if.ex_done       = 1'b0;
        ex_if.ex_done_index = '0;

        // Reset state
        #2;
        chk("rst_ex_valid", 32'(ex_if.ex_valid), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_illegal", 32'(illegal_func), 32'd0);
        chk("rst_rs1", 32'(ex_if.ex_rs1_data), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst_iss_ready", 32'(iss_ready), 32'd1);

        // Mul, both operands ready
        ex_if.ex_ready = 1'b1;
        drive_issue(4'b0010, 4'd5, 3'd2, 1'b1, 8'd6, 3'd0, 1'b1, 8'd7, 3'd0);
        tick();
        iss_valid = 1'b0;
        chk("t1_no_early_disp", 32'(ex_if.ex_valid), 32'd0);
        chk("t1_occ", 32'(occupancy), 32'd1);
        tick();
        chk("t1_ex_valid", 32'(ex_if.ex_valid), 32'd1);
        chk("t1_rs1", 32'(ex_if.ex_rs1_data), 32'd6);
        chk("t1_rs2", 32'(ex_if.ex_rs2_data), 32'd7);
        chk("t1_func", 32'(ex_if.ex_func), 32'd2);
        chk("t1_rd", 32'(ex_if.ex_rd), 32'd5);
        chk("t1_rob", 32'(ex_if.ex_rob), 32'd2);
        chk("t1_idx", 32'(ex_if.ex_rs_index), 32'd0);
        tick();
        chk("t1_valid_drop", 32'(ex_if.ex_valid), 32'd0);
        chk("t1_occ_exec", 32'(occupancy), 32'd1);
        ex_if.ex_done = 1'b1;
        ex_if.ex_done_index = 3'd0;
        tick();
        ex_if.ex_done = 1'b0;
        chk("t1_occ_done", 32'(occupancy), 32'd0);

        // Div waiting on k tag 3
        drive_issue(4'b0011, 4'd3, 3'd1, 1'b1, 8'd40, 3'd0, 1'b0, 8'd0, 3'd3);
        tick();
        iss_valid = 1'b0;
        chk("t2_occ", 32'(occupancy), 32'd1);
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("t2_wait_no_disp", 32'(ex_if.ex_valid), 32'd0);
        end
        cdb_valid = 1'b1;
        cdb_tag   = 3'd3;
        cdb_data  = 8'd5;
        tick();
        cdb_valid = 1'b0;
        chk("t2_no_disp_same", 32'(ex_if.ex_valid), 32'd0);
        tick();
        chk("t2_ex_valid", 32'(ex_if.ex_valid), 32'd1);
        chk("t2_rs1", 32'(ex_if.ex_rs1_data), 32'd40);
        chk("t2_rs2", 32'(ex_if.ex_rs2_data), 32'd5);
        chk("t2_func", 32'(ex_if.ex_func), 32'd3);
        chk("t2_rob", 32'(ex_if.ex_rob), 32'd1);
        tick();
        ex_if.ex_done = 1'b1;
        ex_if.ex_done_index = 3'd0;
        tick();
        ex_if.ex_done = 1'b0;
        chk("t2_occ_done", 32'(occupancy), 32'd0);

        // Issue/broadcast bypass
        drive_issue(4'b0010, 4'd1, 3'd5, 1'b1, 8'd3, 3'd0, 1'b0, 8'd0, 3'd4);
        cdb_valid = 1'b1;
        cdb_tag   = 3'd4;
        cdb_data  = 8'd9;
        tick();
        iss_valid = 1'b0;
        cdb_valid = 1'b0;
        tick();
        chk("t3_ex_valid", 32'(ex_if.ex_valid), 32'd1);
        chk("t3_rs1", 32'(ex_if.ex_rs1_data), 32'd3);
        chk("t3_rs2", 32'(ex_if.ex_rs2_data), 32'd9);
        tick();
        ex_if.ex_done = 1'b1;
        ex_if.ex_done_index = 3'd0;
        tick();
        ex_if.ex_done = 1'b0;
        chk("t3_occ_done", 32'(occupancy), 32'd0);

        // Fill all entries: e0 WAIT(tag6), e1 READY, e2 WAIT(tag7)
        ex_if.ex_ready = 1'b0;
        drive_issue(4'b0010, 4'd8, 3'd4, 1'b0, 8'd0, 3'd6, 1'b1, 8'h10, 3'd0);
        tick();
        drive_issue(4'b0011, 4'd9, 3'd5, 1'b1, 8'd11, 3'd0, 1'b1, 8'd12, 3'd0);
        tick();
        drive_issue(4'b0010, 4'd10, 3'd6, 1'b0, 8'd0, 3'd7, 1'b1, 8'h44, 3'd0);
        tick();
        iss_valid = 1'b0;
        chk("t4_full_ready", 32'(iss_ready), 32'd0);
        chk("t4_full_occ", 32'(occupancy), 32'd3);
        chk("t4_disp_idx1", 32'(ex_if.ex_rs_index), 32'd1);
        drive_issue(4'b0010, 4'd11, 3'd3, 1'b1, 8'd1, 3'd0, 1'b1, 8'd2, 3'd0);
        ex_if.ex_done = 1'b1;
        ex_if.ex_done_index = 3'd0;
        tick();
        iss_valid = 1'b0;
        ex_if.ex_done = 1'b0;
        chk("t4_reject_occ", 32'(occupancy), 32'd3);
        ex_if.ex_ready = 1'b1;
        tick();
        ex_if.ex_ready = 1'b0;
        chk("t4_hs_drop", 32'(ex_if.ex_valid), 32'd0);
        ex_if.ex_done = 1'b1;
        ex_if.ex_done_index = 3'd1;
        tick();
        ex_if.ex_done = 1'b0;
        chk("t4_freed_ready", 32'(iss_ready), 32'd1);
        chk("t4_freed_occ", 32'(occupancy), 32'd2);
        drive_issue(4'b0010, 4'd11, 3'd3, 1'b1, 8'd1, 3'd0, 1'b1, 8'd2, 3'd0);
        tick();
        iss_valid = 1'b0;
        chk("t4_refill_occ", 32'(occupancy), 32'd3);
        tick();
        chk("t4_refill_idx", 32'(ex_if.ex_rs_index), 32'd1);
        chk("t4_refill_rob", 32'(ex_if.ex_rob), 32'd3);
        ex_if.ex_ready = 1'b1;
        tick();
        ex_if.ex_ready = 1'b0;
        ex_if.ex_done = 1'b1;
        ex_if.ex_done_index = 3'd1;
        tick();
        ex_if.ex_done = 1'b0;

        // Backpressure with e0 and e2 READY
        cdb_valid = 1'b1;
        cdb_tag   = 3'd6;
        cdb_data  = 8'h33;
        tick();
        cdb_tag   = 3'd7;
        cdb_data  = 8'h22;
        tick();
        cdb_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            chk("t5_hold_valid", 32'(ex_if.ex_valid), 32'd1);
            chk("t5_hold_idx", 32'(ex_if.ex_rs_index), 32'd0);
            chk("t5_hold_rs1", 32'(ex_if.ex_rs1_data), 32'h33);
            tick();
        end
        chk("t5_rs2", 32'(ex_if.ex_rs2_data), 32'h10);
        ex_if.ex_ready = 1'b1;
        tick();
        ex_if.ex_ready = 1'b0;
        chk("t5_hs_drop", 32'(ex_if.ex_valid), 32'd0);
        tick();
        chk("t5_one_exec", 32'(ex_if.ex_valid), 32'd0);
        ex_if.ex_done = 1'b1;
        ex_if.ex_done_index = 3'd0;
        tick();
        ex_if.ex_done = 1'b0;
        tick();
        chk("t5_e2_valid", 32'(ex_if.ex_valid), 32'd1);
        chk("t5_e2_idx", 32'(ex_if.ex_rs_index), 32'd2);
        chk("t5_e2_rs1", 32'(ex_if.ex_rs1_data), 32'h22);
        chk("t5_e2_rs2", 32'(ex_if.ex_rs2_data), 32'h44);
        chk("t5_occ", 32'(occupancy), 32'd1);

        // Illegal func
        drive_issue(4'b0001, 4'd2, 3'd0, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
        tick();
        iss_valid = 1'b0;
        chk("t6_illegal_hi", 32'(illegal_func), 32'd1);
        chk("t6_illegal_occ", 32'(occupancy), 32'd1);
        tick();
        chk("t6_illegal_lo", 32'(illegal_func), 32'd0);

        // Flush with two entries busy
        drive_issue(4'b0010, 4'd2, 3'd0, 1'b1, 8'd1, 3'd0, 1'b1, 8'd1, 3'd0);
        tick();
        iss_valid = 1'b0;
        chk("t6_pre_flush_occ", 32'(occupancy), 32'd2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t6_flush_occ", 32'(occupancy), 32'd0);
        chk("t6_flush_valid", 32'(ex_if.ex_valid), 32'd0);
        chk("t6_flush_iss_ready", 32'(iss_ready), 32'd1);

        // Reset mid-dispatch
        drive_issue(4'b0010, 4'd4, 3'd7, 1'b1, 8'h55, 3'd0, 1'b1, 8'h66, 3'd0);
        tick();
        iss_valid = 1'b0;
        tick();
        chk("t7_pre_valid", 32'(ex_if.ex_valid), 32'd1);
        chk("t7_pre_rs1", 32'(ex_if.ex_rs1_data), 32'h55);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_rst_valid", 32'(ex_if.ex_valid), 32'd0);
        chk("t7_rst_rs1", 32'(ex_if.ex_rs1_data), 32'd0);
        chk("t7_rst_occ", 32'(occupancy), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("t7_post_iss_ready", 32'(iss_ready), 32'd1);
        chk("t7_post_valid", 32'(ex_if.ex_valid), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
